iq_tune_sequencer: RTL and testbench
====================================

# iq_tune_sequencer

Control block for the I/Q modulator plus CIC decimator receive path. It owns the sample-rate phase-increment register and generates the decimation timebase for the CIC filters: a `clk_out` at 50 % duty and a one-cycle `dec_stb`. Retune requests from the host are accepted with a req/ack handshake. Each new increment is applied only on a decimation boundary, and `out_valid` is held low until the order-3 CIC has flushed stale samples.

## Interface
- `M`, 240: decimation ratio, clk cycles per output sample; must be even and ≥ 4.
- `SETTLE`, 3: decimated samples discarded after reset or retune; equals the CIC order.
- `K_RESET`, 32'h6AAA_AAAA: phase increment after reset, ⌊2^32·100/240⌋.

Ports:
- `clk`  in  1  modulator sampling clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low; all state cleared while low.
- `tune_req`  in  1  level; held high by the host until `tune_ack`.
- `tune_word`  in  32  new phase increment; stable while `tune_req` is high.
- `tune_ack`  out  1  one-cycle pulse on the cycle `phase_inc` takes the new word.
- `phase_inc`  out  32  increment for the NCO phase accumulator.
- `clk_out`  out  1  decimated clock for the CIC comb section.
- `dec_stb`  out  1  one-cycle strobe, last clk cycle of each decimation period.
- `cic_flush`  out  1  clears the CIC integrators and combs.
- `out_valid`  out  1  CIC output is trustworthy.
- `busy`  out  1  high in every state except RUN.

## Operation
- Counter `cnt` runs 0..M-1 and wraps to 0. After rising edge n (counting from the first edge after `reset` goes high), `cnt` = n mod M.
- `clk_out` is registered: 1 when `cnt` < M/2, else 0.
- `dec_stb` = 1 exactly while `cnt` = M-1.
- FSM states: FLUSH, SETTLE, RUN, PEND.
  - FLUSH: `cic_flush`=1. On `dec_stb`, go to SETTLE with the settle counter `sc` = 0.
  - SETTLE: on each `dec_stb`, `sc`++. On the `dec_stb` where `sc` = SETTLE-1, go to RUN.
  - RUN: if `tune_req`=1, capture `tune_word` into a shadow register and go to PEND. This applies even when `dec_stb` is high on the same cycle; the load then happens on the next boundary, M cycles later.
  - PEND: on `dec_stb`, `phase_inc` ← shadow, pulse `tune_ack`, go to SETTLE with `sc` = 0.
- `out_valid` = 1 in RUN and PEND, 0 in FLUSH and SETTLE. `tune_ack` never coincides with `out_valid`=1 on the next cycle.
- A `tune_req` raised in FLUSH or SETTLE is ignored until RUN. The host keeps it asserted.
- The host must drop `tune_req` on the cycle after `tune_ack`. A request still high at RUN re-entry is a new request.
- The `tune_word` value at capture is the one loaded. Later changes before `tune_ack` are ignored.
- `cic_flush` is not reasserted on retune. The CIC is linear, so discarding SETTLE samples is sufficient.

## Timing
- Reset values: `cnt`=0, `clk_out`=0, `dec_stb`=0, `tune_ack`=0, `out_valid`=0, `cic_flush`=1, `busy`=1, `phase_inc`=K_RESET, state FLUSH.
- All outputs are registered and change only after a rising `clk` edge, except under asynchronous reset.
- Retune latency, request to load: 1 cycle to capture, then the next `dec_stb` (up to M cycles later).
- Load to `out_valid`: SETTLE·M cycles.
- Reset asserted mid-operation: all state returns to the reset values immediately, and any pending request is discarded.
- `phase_inc` is constant between loads. Wrap of `cnt` from M-1 to 0 needs no special handling.

## Structure
- Package `fm_pkg` holds:
  - the `seq_state_t` enum (FLUSH, SETTLE, RUN, PEND);
  - the `K_RESET` default;
  - a constant function `tuning_word(f_out, f_clk)` returning ⌊2^32·f_out/f_clk⌋.
- Sub-module `decim_timebase` (param M) contains `cnt`, `clk_out` and `dec_stb`. The top level contains the FSM, the settle counter, and the shadow and `phase_inc` registers.

## Test plan
- Reset release, M=240, SETTLE=3:
  - `dec_stb` high after edges 239, 479, 719, 959;
  - `cic_flush` falls at edge 240;
  - `out_valid` rises at edge 960;
  - `phase_inc` = 32'h6AAA_AAAA throughout.
- `clk_out` duty: over 3 periods, exactly 120 cycles high and 120 low each, with the rising edge aligned to `cnt` wrap.
- Retune at cnt=10 in RUN, `tune_word`=32'h6AB0_0000:
  - capture at the next edge;
  - `tune_ack` and the new `phase_inc` at the following `cnt`=239;
  - `out_valid` low for 720 cycles, then high.
- Request on the cycle `dec_stb` is high in RUN: the load is deferred by 240 cycles. Check that `tune_word` changed after capture is ignored.
- Request during SETTLE: no `tune_ack` until after `out_valid` rises, then normal retune. Check `busy` follows the state.
- Reset pulled low while in PEND: outputs return to their reset values immediately, `phase_inc`=K_RESET, and no `tune_ack` is ever issued for that request.

Source files
------------

// File: rtl/fm_pkg.sv
// Shared types and constants for the I/Q tuning sequencer and its decimation timebase.
package fm_pkg;

   typedef enum logic [1:0] {
      ST_FLUSH,
      ST_SETTLE,
      ST_RUN,
      ST_PEND
   } seq_state_t;

   localparam logic [31:0] K_RESET_DEFAULT = 32'h6AAA_AAAA;

   // Phase increment for an NCO producing f_out from f_clk: floor(2^32 * f_out / f_clk).
   function automatic logic [31:0] tuning_word(input longint unsigned f_out,
                                                input longint unsigned f_clk);
      longint unsigned scaled;
      scaled = (f_out << 32) / f_clk;
      return scaled[31:0];
   endfunction

endpackage

// File: rtl/decim_timebase.sv
// Free-running decimation counter producing the CIC comb clock and the end-of-period strobe.
module decim_timebase #(
   parameter int M = 240
) (
   input  logic clk,
   input  logic reset,
   output logic clk_out,
   output logic dec_stb
);

   localparam int CW = $clog2(M);

   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_next;

   always_comb begin
      cnt_next = (cnt == CW'(M - 1)) ? '0 : cnt + CW'(1);
   end

   // Outputs are decoded from the next count so they line up with cnt after each edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt     <= '0;
         clk_out <= 1'b0;
         dec_stb <= 1'b0;
      end else begin
         cnt     <= cnt_next;
         clk_out <= (cnt_next < CW'(M / 2));
         dec_stb <= (cnt_next == CW'(M - 1));
      end
   end

endmodule

// File: rtl/iq_tune_sequencer.sv
// Retune sequencer: owns the NCO phase increment, applies new words on decimation
// boundaries and holds out_valid low until the CIC has flushed stale samples.
module iq_tune_sequencer
   import fm_pkg::*;
#(
   parameter int          M       = 240,
   parameter int          SETTLE  = 3,
   parameter logic [31:0] K_RESET = K_RESET_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        tune_req,
   input  logic [31:0] tune_word,
   output logic        tune_ack,
   output logic [31:0] phase_inc,
   output logic        clk_out,
   output logic        dec_stb,
   output logic        cic_flush,
   output logic        out_valid,
   output logic        busy
);

   localparam int SCW = (SETTLE > 1) ? $clog2(SETTLE) + 1 : 1;

   seq_state_t     state_q;
   seq_state_t     state_d;
   logic [SCW-1:0] sc;
   logic [31:0]    shadow;

   decim_timebase #(.M(M)) u_timebase (
      .clk     (clk),
      .reset   (reset),
      .clk_out (clk_out),
      .dec_stb (dec_stb)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_FLUSH;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_FLUSH:  if (dec_stb) state_d = ST_SETTLE;
         ST_SETTLE: if (dec_stb && (sc == SCW'(SETTLE - 1))) state_d = ST_RUN;
         ST_RUN:    if (tune_req) state_d = ST_PEND;
         ST_PEND:   if (dec_stb) state_d = ST_SETTLE;
         default:   state_d = ST_FLUSH;
      endcase
   end

   always_comb begin
      cic_flush = (state_q == ST_FLUSH);
      out_valid = (state_q == ST_RUN) || (state_q == ST_PEND);
      busy      = (state_q != ST_RUN);
   end

   // The word is latched at capture so later host changes cannot leak into the load.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sc        <= '0;
         shadow    <= '0;
         phase_inc <= K_RESET;
         tune_ack  <= 1'b0;
      end else begin
         if ((state_d == ST_SETTLE) && (state_q != ST_SETTLE)) begin
            sc <= '0;
         end else if ((state_q == ST_SETTLE) && dec_stb) begin
            sc <= sc + SCW'(1);
         end
         if ((state_q == ST_RUN) && tune_req) begin
            shadow <= tune_word;
         end
         if ((state_q == ST_PEND) && dec_stb) begin
            phase_inc <= shadow;
         end
         tune_ack <= (state_q == ST_PEND) && dec_stb;
      end
   end

endmodule

// File: tb/tb_iq_tune_sequencer.sv
// Self-checking bench for iq_tune_sequencer: reset-release table, directed retune
// corner cases, then randomized host traffic against a cycle-count reference model.
module tb_iq_tune_sequencer;

   localparam int          M  = 240;
   localparam int          ST = 3;
   localparam logic [31:0] KR = 32'h6AAA_AAAA;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        tune_req = 1'b0;
   logic [31:0] tune_word = '0;
   logic        tune_ack;
   logic [31:0] phase_inc;
   logic        clk_out;
   logic        dec_stb;
   logic        cic_flush;
   logic        out_valid;
   logic        busy;

   int vectors = 0;
   int miscompares = 0;

   iq_tune_sequencer #(.M(M), .SETTLE(ST), .K_RESET(KR)) dut (
      .clk       (clk),
      .reset     (reset),
      .tune_req  (tune_req),
      .tune_word (tune_word),
      .tune_ack  (tune_ack),
      .phase_inc (phase_inc),
      .clk_out   (clk_out),
      .dec_stb   (dec_stb),
      .cic_flush (cic_flush),
      .out_valid (out_valid),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Reference model: edges since reset, plus the sequencer's state in plain terms.
   typedef enum int {M_FLUSH, M_SETTLE, M_RUN, M_PEND} mstate_t;
   int          m_edges;
   mstate_t     m_st;
   int          m_sc;
   logic [31:0] m_shadow;
   logic [31:0] m_pinc;
   logic        m_ack;

   typedef struct packed {
      logic        ack;
      logic [31:0] pinc;
      logic        clko;
      logic        stb;
      logic        flush;
      logic        valid;
      logic        busy;
   } obs_t;

   typedef struct {
      int   edge_n;
      logic stb;
      logic flush;
      logic valid;
      logic clko;
      logic busy;
   } rv_t;

   task automatic model_reset();
      m_edges  = 0;
      m_st     = M_FLUSH;
      m_sc     = 0;
      m_shadow = '0;
      m_pinc   = KR;
      m_ack    = 1'b0;
   endtask

   task automatic model_edge(input logic req, input logic [31:0] word);
      bit stb;
      stb   = ((m_edges % M) == M - 1);
      m_ack = 1'b0;
      case (m_st)
         M_FLUSH:  if (stb) begin m_st = M_SETTLE; m_sc = 0; end
         M_SETTLE: if (stb) begin
                      if (m_sc == ST - 1) m_st = M_RUN;
                      m_sc++;
                   end
         M_RUN:    if (req) begin m_shadow = word; m_st = M_PEND; end
         M_PEND:   if (stb) begin m_pinc = m_shadow; m_ack = 1'b1; m_st = M_SETTLE; m_sc = 0; end
         default:  m_st = M_FLUSH;
      endcase
      m_edges++;
   endtask

   function automatic obs_t expected();
      obs_t e;
      e.ack   = m_ack;
      e.pinc  = m_pinc;
      e.clko  = (m_edges > 0) && ((m_edges % M) < M / 2);
      e.stb   = ((m_edges % M) == M - 1);
      e.flush = (m_st == M_FLUSH);
      e.valid = (m_st == M_RUN) || (m_st == M_PEND);
      e.busy  = (m_st != M_RUN);
      return e;
   endfunction

   function automatic obs_t observed();
      obs_t o;
      o.ack   = tune_ack;
      o.pinc  = phase_inc;
      o.clko  = clk_out;
      o.stb   = dec_stb;
      o.flush = cic_flush;
      o.valid = out_valid;
      o.busy  = busy;
      return o;
   endfunction

   task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("[TB] FAIL %s at edge %0d: got %h, expected %h", name, m_edges, got, want);
      end
   endtask

   task automatic compare_model(input string name);
      obs_t o;
      obs_t e;
      o = observed();
      e = expected();
      vectors++;
      if (o !== e) begin
         miscompares++;
         $display("[TB] FAIL %s at edge %0d: got ack=%b pinc=%h clk_out=%b stb=%b flush=%b valid=%b busy=%b, expected ack=%b pinc=%h clk_out=%b stb=%b flush=%b valid=%b busy=%b",
                  name, m_edges, o.ack, o.pinc, o.clko, o.stb, o.flush, o.valid, o.busy,
                  e.ack, e.pinc, e.clko, e.stb, e.flush, e.valid, e.busy);
      end
   endtask

   // One clock: model sees the inputs present at the edge; outputs compared 1 time unit later.
   task automatic apply_cycle();
      logic        r;
      logic [31:0] w;
      r = tune_req;
      w = tune_word;
      @(posedge clk);
      if (reset) model_edge(r, w);
      #1;
      compare_model("cycle");
      if (m_ack) tune_req = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      check_output({tag, "_ack"},   32'(tune_ack),  32'd0);
      check_output({tag, "_pinc"},  phase_inc,      KR);
      check_output({tag, "_clko"},  32'(clk_out),   32'd0);
      check_output({tag, "_stb"},   32'(dec_stb),   32'd0);
      check_output({tag, "_flush"}, 32'(cic_flush), 32'd1);
      check_output({tag, "_valid"}, 32'(out_valid), 32'd0);
      check_output({tag, "_busy"},  32'(busy),      32'd1);
   endtask

   task automatic wait_ack(output int t, input int budget);
      t = 0;
      while (!tune_ack && t < budget) begin
         apply_cycle();
         t++;
      end
      check_output("ack_seen", 32'(tune_ack), 32'd1);
   endtask

   initial begin
      #2ms;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rv_t         tbl[10];
      int          t;
      int          hi;
      int          lo;
      int          acks;
      bit          seen_valid;
      bit          seen_run;
      logic [31:0] word_a;

      tbl[0] = '{1,   1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      tbl[1] = '{119, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      tbl[2] = '{120, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[3] = '{239, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[4] = '{240, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      tbl[5] = '{479, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[6] = '{719, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[7] = '{959, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[8] = '{960, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[9] = '{961, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_reset_values("reset");
      reset = 1'b1;

      // Reset release timeline
      for (int i = 0; i < 10; i++) begin
         while (m_edges < tbl[i].edge_n) apply_cycle();
         check_output($sformatf("e%0d_stb", tbl[i].edge_n),   32'(dec_stb),   32'(tbl[i].stb));
         check_output($sformatf("e%0d_flush", tbl[i].edge_n), 32'(cic_flush), 32'(tbl[i].flush));
         check_output($sformatf("e%0d_valid", tbl[i].edge_n), 32'(out_valid), 32'(tbl[i].valid));
         check_output($sformatf("e%0d_clko", tbl[i].edge_n),  32'(clk_out),   32'(tbl[i].clko));
         check_output($sformatf("e%0d_busy", tbl[i].edge_n),  32'(busy),      32'(tbl[i].busy));
         check_output($sformatf("e%0d_pinc", tbl[i].edge_n),  phase_inc,      KR);
      end

      // clk_out duty over three periods, rising at the counter wrap
      while ((m_edges % M) != 0) apply_cycle();
      for (int p = 0; p < 3; p++) begin
         check_output("duty_rise", 32'(clk_out), 32'd1);
         hi = 0;
         for (int i = 0; i < M; i++) begin
            if (clk_out) hi++;
            apply_cycle();
         end
         check_output("duty_high", hi, M / 2);
      end

      // Retune at cnt=10
      while ((m_edges % M) != 10) apply_cycle();
      tune_word = 32'h6AB0_0000;
      tune_req  = 1'b1;
      apply_cycle();
      check_output("capture_busy", 32'(busy), 32'd1);
      wait_ack(t, 2 * M);
      check_output("retune_latency", t, 229);
      check_output("retune_pinc", phase_inc, 32'h6AB0_0000);
      check_output("ack_valid_low", 32'(out_valid), 32'd0);
      lo = 1;
      while (!out_valid && lo < 2000) begin
         apply_cycle();
         if (!out_valid) lo++;
      end
      check_output("settle_len", lo, ST * M);

      // Request on the strobe cycle, word changed after capture
      while ((m_edges % M) != M - 1) apply_cycle();
      check_output("stb_in_run", 32'(dec_stb), 32'd1);
      word_a    = 32'h1234_5678;
      tune_word = word_a;
      tune_req  = 1'b1;
      apply_cycle();
      tune_word = 32'hDEAD_BEEF;
      wait_ack(t, 2 * M);
      check_output("deferred_latency", t, M);
      check_output("deferred_pinc", phase_inc, word_a);

      // Request raised during SETTLE waits for RUN
      apply_cycle();
      tune_word  = 32'h0F0F_0F0F;
      tune_req   = 1'b1;
      seen_valid = 1'b0;
      seen_run   = 1'b0;
      apply_cycle();
      check_output("settle_busy", 32'(busy), 32'd1);
      t = 1;
      while (!tune_ack && t < 3000) begin
         if (out_valid) seen_valid = 1'b1;
         if (!busy) seen_run = 1'b1;
         apply_cycle();
         t++;
      end
      check_output("settle_req_ack", 32'(tune_ack), 32'd1);
      check_output("settle_req_latency", t, ST * M + M - 1);
      check_output("valid_before_ack", 32'(seen_valid), 32'd1);
      check_output("run_seen", 32'(seen_run), 32'd1);
      check_output("settle_req_pinc", phase_inc, 32'h0F0F_0F0F);

      // Reset while PEND discards the request
      t = 0;
      while (!out_valid && t < 2000) begin
         apply_cycle();
         t++;
      end
      tune_word = 32'h7777_0000;
      tune_req  = 1'b1;
      apply_cycle();
      check_output("pend_busy", 32'(busy), 32'd1);
      repeat (20) apply_cycle();
      reset = 1'b0;
      #1;
      check_reset_values("async");
      model_reset();
      tune_req = 1'b0;
      repeat (3) apply_cycle();
      reset = 1'b1;
      acks  = 0;
      repeat (4 * M) begin
         apply_cycle();
         if (tune_ack) acks++;
      end
      check_output("no_ack_after_reset", acks, 0);
      check_output("pinc_after_reset", phase_inc, KR);

      // Randomized host traffic
      for (int i = 0; i < 8000; i++) begin
         if (($urandom % 4000) == 0) begin
            reset    = 1'b0;
            model_reset();
            tune_req = 1'b0;
            #1;
            compare_model("rand_reset");
            apply_cycle();
            reset = 1'b1;
         end else if (!tune_req && (($urandom % 150) == 0)) begin
            tune_word = $urandom;
            tune_req  = 1'b1;
         end else if (tune_req && (m_st == M_PEND) && (($urandom % 4) == 0)) begin
            tune_word = $urandom;
         end
         apply_cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
